icache_port_arbiter: RTL and testbench
======================================

ICACHE_PORT_ARBITER -- requirements
Module: icache_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive lost IDLE arbitration cycles after which requester 1 wins once.
REQ-002 SHALL have one clock and a synchronous, active-low reset.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  synchronous active-low reset.
REQ-005 flush_i  input  1  global kill of the granted request and any in-flight fetch.
REQ-006 req0_i  input  icache_dreq_i_t  demand fetch request (frontend); higher priority.
REQ-007 rsp0_o  output  icache_dreq_o_t  response/ready to requester 0.
REQ-008 req1_i  input  icache_dreq_i_t  prefetch request; lower priority.
REQ-009 rsp1_o  output  icache_dreq_o_t  response/ready to requester 1.
REQ-010 ic_req_o  output  icache_dreq_i_t  request to the single icache port.
REQ-011 ic_rsp_i  input  icache_dreq_o_t  icache ready, valid, data, vaddr, ex.
REQ-012 owner_o  output  2  {busy, owner index} of the outstanding fetch, for debug.

Function
REQ-013 SHALL keep one outstanding icache fetch; FSM states IDLE, BUSY0, BUSY1, KILLED.
REQ-014 IDLE grant: requester 0 if req0_i.req, else requester 1; requester 1 wins when both request and starve counter equals STARVE_LIMIT.
REQ-015 IDLE: ic_req_o.req, vaddr, kill_s1 pass through combinationally from granted requester (zero latency); ic_req_o.kill_s1 = granted kill_s1 | flush_i.
REQ-016 Granted requester's ready = ic_rsp_i.ready in IDLE; non-granted ready = 0; both ready = 0 outside IDLE.
REQ-017 Issue = IDLE & granted req & ic_rsp_i.ready & ~ic_req_o.kill_s1; next state BUSY<granted>.
REQ-018 BUSY: ic_req_o.req = 0; ic_rsp_i valid/data/vaddr/ex routed combinationally to owner only; non-owner valid = 0.
REQ-019 BUSY & ic_rsp_i.valid & no kill -> IDLE next cycle; new issue possible that cycle.
REQ-020 BUSY: ic_req_o.kill_s2 = owner kill_s2 | flush_i; non-owner kill_s2 ignored.
REQ-021 BUSY & kill (owner kill_s2 or flush_i): owner valid = 0 that cycle; -> KILLED, even if ic_rsp_i.valid same cycle (then -> IDLE directly).
REQ-022 KILLED: all requester valid = 0, ready = 0; ic_rsp_i.valid dropped; -> IDLE on ic_rsp_i.valid or ic_rsp_i.ready.
REQ-023 Starve counter ($clog2(STARVE_LIMIT)+1 bits): +1 each IDLE cycle both requesters active and requester 0 issues; saturates at STARVE_LIMIT; clears when requester 1 issues.
REQ-024 flush_i in IDLE: no issue; state stays IDLE; counter unchanged.
REQ-025 ic_req_o.kill_s2 = flush_i in IDLE and KILLED.

Reset
REQ-026 rst_ni low at clock edge: state IDLE, starve counter 0.
REQ-027 While rst_ni low: ic_req_o.req 0, rsp0_o/rsp1_o ready and valid 0, owner_o 0.
REQ-028 Reset mid-fetch abandons the fetch; late ic_rsp_i.valid after reset is not forwarded (outputs gated while rst_ni low; IDLE ignores valid).

Structure
REQ-029 arb_state_e enum and default STARVE_LIMIT constant SHALL live in ariane_pkg; icache structs reused unchanged.
REQ-030 Single module, no sub-module; starve counter and FSM inline.

Verification
REQ-031 Only req1, ready=1, vaddr 0x8000_0010 -> issue cycle 0, BUSY1, valid routed to rsp1_o only, owner_o=2'b11.
REQ-032 Both request every cycle, STARVE_LIMIT=4, 1-cycle icache -> grant sequence 0,0,0,0,1,0,0,0,0,1.
REQ-033 BUSY0, req0 kill_s2 with ic valid next cycle -> rsp0_o.valid 0, KILLED, IDLE after that valid.
REQ-034 BUSY1 with flush_i and ic valid same cycle -> rsp1_o.valid 0, kill_s2 1, state IDLE next cycle.
REQ-035 rst_ni low in BUSY0 then ic valid post-reset -> no rsp0_o.valid; counter 0; IDLE.
REQ-036 IDLE, req0 with kill_s1=1, ready=1 -> no issue, ic_req_o.kill_s1=1, stays IDLE.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared frontend types: icache request/response structs, arbiter state enum and default starvation limit.
package ariane_pkg;

    localparam int unsigned VLEN             = 64;
    localparam int unsigned FETCH_WIDTH      = 32;
    localparam int unsigned ARB_STARVE_LIMIT = 4;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic            req;
        logic            kill_s1;
        logic            kill_s2;
        logic            spec;
        logic [VLEN-1:0] vaddr;
    } icache_dreq_i_t;

    typedef struct packed {
        logic                   ready;
        logic                   valid;
        logic [FETCH_WIDTH-1:0] data;
        logic [VLEN-1:0]        vaddr;
        exception_t             ex;
    } icache_dreq_o_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY0,
        BUSY1,
        KILLED
    } arb_state_e;

endpackage

// File: rtl/icache_port_arbiter.sv
// Shares one icache port between a demand (0) and a prefetch (1) requester, one fetch outstanding.
// Zero-latency request/response routing; requester 1 wins once after STARVE_LIMIT lost IDLE cycles.
module icache_port_arbiter
    import ariane_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  icache_dreq_i_t req0_i,
    output icache_dreq_o_t rsp0_o,
    input  icache_dreq_i_t req1_i,
    output icache_dreq_o_t rsp1_o,
    output icache_dreq_i_t ic_req_o,
    input  icache_dreq_o_t ic_rsp_i,
    output logic [1:0]     owner_o
);

    localparam int unsigned     CNT_W   = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic             gnt1;
    logic             gnt_req;
    logic             gnt_kill_s1;
    logic             issue;
    logic             own_kill;

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        ic_req_o = '0;
        rsp0_o   = '0;
        rsp1_o   = '0;
        owner_o  = 2'b00;

        gnt1        = req1_i.req & (~req0_i.req | (starve_q == CNT_MAX));
        gnt_req     = gnt1 ? req1_i.req : req0_i.req;
        gnt_kill_s1 = (gnt1 ? req1_i.kill_s1 : req0_i.kill_s1) | flush_i;
        issue       = 1'b0;
        own_kill    = ((state_q == BUSY1) ? req1_i.kill_s2 : req0_i.kill_s2) | flush_i;

        unique case (state_q)
            IDLE: begin
                ic_req_o.req     = gnt_req;
                ic_req_o.vaddr   = gnt1 ? req1_i.vaddr : req0_i.vaddr;
                ic_req_o.spec    = gnt1 ? req1_i.spec : req0_i.spec;
                ic_req_o.kill_s1 = gnt_kill_s1;
                ic_req_o.kill_s2 = flush_i;
                if (gnt1) rsp1_o.ready = ic_rsp_i.ready;
                else      rsp0_o.ready = ic_rsp_i.ready;

                issue = gnt_req & ic_rsp_i.ready & ~gnt_kill_s1;
                if (issue) begin
                    state_d = gnt1 ? BUSY1 : BUSY0;
                    // Only losses while the prefetcher is actually waiting count towards starvation.
                    if (gnt1)                                   starve_d = '0;
                    else if (req1_i.req && starve_q != CNT_MAX) starve_d = starve_q + 1'b1;
                end
            end
            BUSY0, BUSY1: begin
                ic_req_o.vaddr   = (state_q == BUSY1) ? req1_i.vaddr : req0_i.vaddr;
                ic_req_o.kill_s2 = own_kill;
                owner_o          = {1'b1, state_q == BUSY1};
                if (state_q == BUSY1) begin
                    rsp1_o       = ic_rsp_i;
                    rsp1_o.ready = 1'b0;
                    rsp1_o.valid = ic_rsp_i.valid & ~own_kill;
                end else begin
                    rsp0_o       = ic_rsp_i;
                    rsp0_o.ready = 1'b0;
                    rsp0_o.valid = ic_rsp_i.valid & ~own_kill;
                end
                if (own_kill)            state_d = ic_rsp_i.valid ? IDLE : KILLED;
                else if (ic_rsp_i.valid) state_d = IDLE;
            end
            KILLED: begin
                ic_req_o.kill_s2 = flush_i;
                if (ic_rsp_i.valid || ic_rsp_i.ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Hold handshakes quiet during reset so a late response from an abandoned fetch is never seen.
        if (!rst_ni) begin
            ic_req_o.req = 1'b0;
            rsp0_o.ready = 1'b0;
            rsp0_o.valid = 1'b0;
            rsp1_o.ready = 1'b0;
            rsp1_o.valid = 1'b0;
            owner_o      = 2'b00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_icache_port_arbiter.sv
// Directed scenarios plus randomized traffic checked by a transaction-level reference model and scoreboard.
module tb_icache_port_arbiter;
    import ariane_pkg::*;

    localparam int LIMIT = 4;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           flush_i;
    icache_dreq_i_t req0_i, req1_i, ic_req_o;
    icache_dreq_o_t rsp0_o, rsp1_o, ic_rsp_i;
    logic [1:0]     owner_o;

    icache_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .req0_i  (req0_i),
        .rsp0_o  (rsp0_o),
        .req1_i  (req1_i),
        .rsp1_o  (rsp1_o),
        .ic_req_o(ic_req_o),
        .ic_rsp_i(ic_rsp_i),
        .owner_o (owner_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          id;
        logic [63:0] vaddr;
    } iss_t;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    iss_t        iss_q[$];
    logic [31:0] rsp0_q[$];
    logic [31:0] rsp1_q[$];
    int          gseq[$];
    int          exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    // Reference model state: who holds the port (-1 free, 0/1 owner, 2 killed) and prefetcher losses.
    int             owner_m;
    int             losses;
    int             ic_cnt;
    int             g;
    bit             pend[2];
    logic [63:0]    addr[2];
    icache_dreq_i_t rq[2];
    logic           m_iss;
    iss_t           e;
    logic [31:0]    ed;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic idle_in();
        req0_i   = '0;
        req1_i   = '0;
        flush_i  = 1'b0;
        ic_rsp_i = '0;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    // Both requesters asking continuously against a one-cycle icache; records who is offered the port.
    task automatic run_grants(input int n);
        gseq.delete();
        idle_in();
        req0_i.req = 1'b1; req0_i.vaddr = 64'h1000;
        req1_i.req = 1'b1; req1_i.vaddr = 64'h2000;
        ic_rsp_i.ready = 1'b1;
        ic_rsp_i.valid = 1'b1;
        for (int c = 0; c < 4 * n + 8; c++) begin
            smp();
            if (ic_req_o.req && (rsp0_o.ready || rsp1_o.ready)) gseq.push_back(int'(rsp1_o.ready));
            cyc();
            if (gseq.size() == n) break;
        end
        idle_in();
        if (gseq.size() != n) fail("grant_timeout", 64'(gseq.size()), 64'(n));
    endtask

    always @(negedge clk_i) begin
        if (mon_en) begin
            check("ready_exclusive", 64'(rsp0_o.ready & rsp1_o.ready), 64'd0);
            m_iss = ic_req_o.req & ic_rsp_i.ready & ~ic_req_o.kill_s1;
            if (m_iss) begin
                if (iss_q.size() == 0) fail("issue_unexpected", 64'd1, 64'd0);
                else begin
                    e = iss_q.pop_front();
                    check("issue_id", 64'(rsp1_o.ready), 64'(e.id));
                    check("issue_vaddr", ic_req_o.vaddr, e.vaddr);
                end
            end else if (iss_q.size() != 0) begin
                e = iss_q.pop_front();
                fail("issue_missing", 64'd0, 64'd1);
            end
            if (rsp0_o.valid) begin
                if (rsp0_q.size() == 0) fail("rsp0_unexpected", 64'd1, 64'd0);
                else begin ed = rsp0_q.pop_front(); check("rsp0_data", 64'(rsp0_o.data), 64'(ed)); end
            end else if (rsp0_q.size() != 0) begin
                ed = rsp0_q.pop_front();
                fail("rsp0_missing", 64'd0, 64'd1);
            end
            if (rsp1_o.valid) begin
                if (rsp1_q.size() == 0) fail("rsp1_unexpected", 64'd1, 64'd0);
                else begin ed = rsp1_q.pop_front(); check("rsp1_data", 64'(rsp1_o.data), 64'(ed)); end
            end else if (rsp1_q.size() != 0) begin
                ed = rsp1_q.pop_front();
                fail("rsp1_missing", 64'd0, 64'd1);
            end
        end
    end

    initial begin
        // Reset gating: outputs quiet even with traffic present.
        idle_in();
        rst_ni = 1'b0;
        req0_i.req = 1'b1; req0_i.vaddr = 64'h40;
        ic_rsp_i.ready = 1'b1; ic_rsp_i.valid = 1'b1;
        smp();
        check("rst_ic_req", 64'(ic_req_o.req), 64'd0);
        check("rst_rdy0", 64'(rsp0_o.ready), 64'd0);
        check("rst_vld0", 64'(rsp0_o.valid), 64'd0);
        check("rst_owner", 64'(owner_o), 64'd0);
        cyc(); cyc();
        idle_in();
        rst_ni = 1'b1;

        // Lone prefetch request.
        req1_i.req = 1'b1; req1_i.vaddr = 64'h8000_0010; ic_rsp_i.ready = 1'b1;
        smp();
        check("r1_rdy1", 64'(rsp1_o.ready), 64'd1);
        check("r1_rdy0", 64'(rsp0_o.ready), 64'd0);
        check("r1_ic_req", 64'(ic_req_o.req), 64'd1);
        check("r1_vaddr", ic_req_o.vaddr, 64'h8000_0010);
        cyc(); idle_in();
        ic_rsp_i.valid = 1'b1; ic_rsp_i.data = 32'hCAFE_0031;
        smp();
        check("r1_owner", 64'(owner_o), 64'b11);
        check("r1_vld1", 64'(rsp1_o.valid), 64'd1);
        check("r1_data1", 64'(rsp1_o.data), 64'hCAFE_0031);
        check("r1_vld0", 64'(rsp0_o.valid), 64'd0);
        cyc(); idle_in();
        smp();
        check("r1_idle_owner", 64'(owner_o), 64'd0);

        // Owner kill_s2 while BUSY0, then the icache answers.
        req0_i.req = 1'b1; req0_i.vaddr = 64'h100; ic_rsp_i.ready = 1'b1;
        cyc(); idle_in();
        req0_i.kill_s2 = 1'b1;
        smp();
        check("k0_owner", 64'(owner_o), 64'b10);
        check("k0_kill_s2", 64'(ic_req_o.kill_s2), 64'd1);
        check("k0_vld0_kill", 64'(rsp0_o.valid), 64'd0);
        cyc(); idle_in();
        ic_rsp_i.valid = 1'b1; req1_i.req = 1'b1;
        smp();
        check("k0_vld0", 64'(rsp0_o.valid), 64'd0);
        check("k0_killed_rdy1", 64'(rsp1_o.ready), 64'd0);
        cyc(); idle_in();
        req1_i.req = 1'b1; ic_rsp_i.ready = 1'b1;
        smp();
        check("k0_idle_rdy1", 64'(rsp1_o.ready), 64'd1);
        idle_in();

        // Flush coinciding with the icache response in BUSY1.
        cyc();
        req1_i.req = 1'b1; req1_i.vaddr = 64'h200; ic_rsp_i.ready = 1'b1;
        cyc(); idle_in();
        flush_i = 1'b1; ic_rsp_i.valid = 1'b1; ic_rsp_i.data = 32'h1234;
        smp();
        check("f1_vld1", 64'(rsp1_o.valid), 64'd0);
        check("f1_kill_s2", 64'(ic_req_o.kill_s2), 64'd1);
        check("f1_owner", 64'(owner_o), 64'b11);
        cyc(); idle_in();
        req0_i.req = 1'b1; ic_rsp_i.ready = 1'b1;
        smp();
        check("f1_idle_rdy0", 64'(rsp0_o.ready), 64'd1);
        check("f1_idle_owner", 64'(owner_o), 64'd0);
        idle_in();

        // kill_s1 on the granted request blocks the issue.
        cyc();
        req0_i.req = 1'b1; req0_i.kill_s1 = 1'b1; ic_rsp_i.ready = 1'b1;
        smp();
        check("ks1_kill_s1", 64'(ic_req_o.kill_s1), 64'd1);
        cyc(); idle_in();
        req0_i.req = 1'b1; ic_rsp_i.ready = 1'b1;
        smp();
        check("ks1_owner", 64'(owner_o), 64'd0);
        check("ks1_rdy0", 64'(rsp0_o.ready), 64'd1);
        idle_in();

        // Flush in IDLE blocks the issue.
        cyc();
        req1_i.req = 1'b1; ic_rsp_i.ready = 1'b1; flush_i = 1'b1;
        smp();
        check("fl_kill_s1", 64'(ic_req_o.kill_s1), 64'd1);
        check("fl_kill_s2", 64'(ic_req_o.kill_s2), 64'd1);
        cyc(); idle_in();
        smp();
        check("fl_owner", 64'(owner_o), 64'd0);

        // Build up starvation count, reset mid-fetch in BUSY0, late valid must be dropped.
        cyc();
        run_grants(2);
        smp();
        check("rs_owner_busy0", 64'(owner_o), 64'b10);
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        ic_rsp_i.valid = 1'b1; ic_rsp_i.data = 32'hDEAD;
        smp();
        check("rs_vld0", 64'(rsp0_o.valid), 64'd0);
        check("rs_owner", 64'(owner_o), 64'd0);
        cyc(); idle_in();

        // Starvation pattern from a cleared counter.
        run_grants(10);
        for (int i = 0; i < 10; i++)
            if (i < gseq.size()) check($sformatf("grant_seq_%0d", i), 64'(gseq[i]), 64'(exp_seq[i]));

        // Randomized traffic.
        rst_ni = 1'b0;
        cyc(); cyc();
        rst_ni = 1'b1;
        owner_m = -1; losses = 0; ic_cnt = -1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            for (int k = 0; k < 2; k++) begin
                if (!pend[k] && $urandom_range(2) == 0) begin
                    pend[k] = 1'b1;
                    addr[k] = {32'h0, $urandom} & ~64'h3;
                end
                rq[k].req     = pend[k];
                rq[k].kill_s1 = ($urandom_range(11) == 0);
                rq[k].kill_s2 = ($urandom_range(9) == 0);
                rq[k].spec    = 1'($urandom_range(1));
                rq[k].vaddr   = addr[k];
            end
            req0_i  = rq[0];
            req1_i  = rq[1];
            flush_i = ($urandom_range(19) == 0);
            if (ic_cnt > 0) ic_cnt--;
            ic_rsp_i          = '0;
            ic_rsp_i.ready    = ($urandom_range(3) != 0);
            ic_rsp_i.valid    = (ic_cnt == 0) || (ic_cnt < 0 && $urandom_range(15) == 0);
            ic_rsp_i.data     = $urandom;
            ic_rsp_i.vaddr    = {32'h0, $urandom};
            ic_rsp_i.ex.valid = 1'($urandom_range(1));
            if (ic_cnt == 0) ic_cnt = -1;

            if (owner_m == -1) begin
                g = (pend[1] && (!pend[0] || losses >= LIMIT)) ? 1 : 0;
                if (pend[g] && ic_rsp_i.ready) begin
                    if (!(rq[g].kill_s1 || flush_i)) begin
                        iss_q.push_back('{g, addr[g]});
                        owner_m = g;
                        ic_cnt  = $urandom_range(1, 3);
                        if (g == 1)       losses = 0;
                        else if (pend[1]) losses = (losses + 1 > LIMIT) ? LIMIT : losses + 1;
                    end
                    pend[g] = 1'b0;
                end
            end else if (owner_m == 0 || owner_m == 1) begin
                if (ic_rsp_i.valid && !(rq[owner_m].kill_s2 || flush_i)) begin
                    if (owner_m == 0) rsp0_q.push_back(ic_rsp_i.data);
                    else              rsp1_q.push_back(ic_rsp_i.data);
                    owner_m = -1;
                end else if (rq[owner_m].kill_s2 || flush_i) begin
                    owner_m = ic_rsp_i.valid ? -1 : 2;
                end
            end else if (ic_rsp_i.valid || ic_rsp_i.ready) begin
                owner_m = -1;
            end
        end
        smp();
        mon_en = 1'b0;
        check("iss_q_empty", 64'(iss_q.size()), 64'd0);
        check("rsp_q_empty", 64'(rsp0_q.size() + rsp1_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
